// File: rtl/multi_cycle_control_pkg.sv
// rtl/multi_cycle_control_pkg.sv - shared opcodes, ALU codes, state encoding and EXEC decode helper
// Purpose: one definition point for the control unit and the ALU control.
// Ports: none (package).
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC    = 4'd2,
        S_WB      = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEMACC  = 4'd5,
        S_MEMWB   = 4'd6,
        S_BRANCH  = 4'd7,
        S_JUMP    = 4'd8,
        S_TRAP    = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_ADDU = 4'h8;
    localparam logic [3:0] ALU_XOR  = 4'hA;
    localparam logic [3:0] ALU_SLTU = 4'hB;
    localparam logic [3:0] ALU_LUI  = 4'hE;
    localparam logic [3:0] ALU_FUNC = 4'hF;

    typedef struct packed {
        logic [3:0] alu;
        logic       sign_ext;
    } exec_ctrl_t;

    // ALU operation and immediate extension for the EXEC state.
    function automatic exec_ctrl_t exec_decode(input logic [5:0] op);
        exec_ctrl_t c;
        c = '{alu: ALU_FUNC, sign_ext: 1'b0};
        case (op)
            OP_ORI:   c = '{alu: ALU_OR,   sign_ext: 1'b0};
            OP_ADDI:  c = '{alu: ALU_ADD,  sign_ext: 1'b1};
            OP_ADDIU: c = '{alu: ALU_ADDU, sign_ext: 1'b0};
            OP_ANDI:  c = '{alu: ALU_AND,  sign_ext: 1'b0};
            OP_LUI:   c = '{alu: ALU_LUI,  sign_ext: 1'b0};
            OP_SLTI:  c = '{alu: ALU_SLT,  sign_ext: 1'b1};
            OP_SLTIU: c = '{alu: ALU_SLTU, sign_ext: 1'b1};
            OP_XORI:  c = '{alu: ALU_XOR,  sign_ext: 1'b0};
            default:  c = '{alu: ALU_FUNC, sign_ext: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// rtl/multi_cycle_control_if.sv - control unit datapath-facing signal bundle
// Purpose: groups the opcode/status inputs and datapath control outputs.
// Modports: master = control unit (drives controls), slave = datapath side.
interface multi_cycle_control_if #(
    parameter int ALUOP_WIDTH = 4
);
    logic [5:0]             Opcode;
    logic                   Zero;
    logic                   MemReady;
    logic                   PCWrite;
    logic                   IRWrite;
    logic                   IorD;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   MemToReg;
    logic                   RegDst;
    logic                   RegWrite;
    logic                   ALUSrcA;
    logic                   SignExtend;
    logic                   Trap;
    logic [1:0]             ALUSrcB;
    logic [1:0]             PCSource;
    logic [ALUOP_WIDTH-1:0] ALUOp;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
               RegWrite, ALUSrcA, SignExtend, Trap, ALUSrcB, PCSource, ALUOp
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
               RegWrite, ALUSrcA, SignExtend, Trap, ALUSrcB, PCSource, ALUOp
    );
endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory wait counter with timeout flag
// Purpose: counts cycles spent waiting on MemReady.
// Ports: CLK; i_clear (sync clear, wins); i_enable (count this cycle);
//        i_limit (timeout cycles, >=1); o_expired (this wait cycle reaches the limit).
module mem_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // The count holds completed wait cycles; the current cycle is the
    // limit-th one when count == limit-1.
    assign o_expired = (r_count >= (i_limit - WIDTH'(1)));
endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle CPU control FSM with memory wait timeout
// Purpose: sequences fetch/decode/execute/memory/branch/jump and traps on
//          illegal opcodes or memory timeouts.
// Ports: CLK, Reset (sync, active high); bus (master modport): Opcode, Zero,
//        MemReady in; PC/IR/memory/register/ALU controls and Trap out.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int ALUOP_WIDTH = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    Reset,
    multi_cycle_control_if.master   bus
);
    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic       w_expired;
    logic       w_wait_state;
    exec_ctrl_t w_exec;

    logic       w_pcwrite, w_irwrite, w_iord, w_memread, w_memwrite, w_memtoreg;
    logic       w_regdst, w_regwrite, w_alusrca, w_signext, w_trap;
    logic [1:0] w_alusrcb, w_pcsource;
    logic [3:0] w_alu;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.Opcode;
            end
        end
    end

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMACC);
    assign w_exec       = exec_decode(r_opcode);

    // Any state change clears the counter, so each FETCH/MEMACC visit starts at 0.
    mem_wait_timer #(.WIDTH(8)) u_timer (
        .CLK       (CLK),
        .i_clear   (Reset || (w_next != r_state)),
        .i_enable  (w_wait_state && !bus.MemReady),
        .i_limit   (8'(MEM_TIMEOUT)),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_iord     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regdst   = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_signext  = 1'b0;
        w_trap     = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsource = 2'b00;
        w_alu      = ALU_AND;

        if (Reset) begin
            // Quiet fetch-like setup: no writes while reset is held.
            w_next    = S_FETCH;
            w_memread = 1'b1;
            w_alusrcb = 2'b01;
            w_alu     = ALU_ADD;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_memread = 1'b1;
                    w_alusrcb = 2'b01;
                    w_alu     = ALU_ADD;
                    if (bus.MemReady) begin
                        w_irwrite = 1'b1;
                        w_pcwrite = 1'b1;
                        w_next    = S_DECODE;
                    end else if (w_expired) begin
                        w_next = S_TRAP;
                    end
                end
                S_DECODE: begin
                    w_alusrcb = 2'b11;
                    w_alu     = ALU_ADD;
                    w_signext = 1'b1;
                    case (bus.Opcode)
                        OP_RTYPE, OP_ORI, OP_ADDI, OP_ADDIU, OP_ANDI,
                        OP_LUI, OP_SLTI, OP_SLTIU, OP_XORI: w_next = S_EXEC;
                        OP_LW, OP_SW:                       w_next = S_MEMADDR;
                        OP_BEQ:                             w_next = S_BRANCH;
                        OP_J:                               w_next = S_JUMP;
                        default:                            w_next = S_TRAP;
                    endcase
                end
                S_EXEC: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = (r_opcode == OP_RTYPE) ? 2'b00 : 2'b10;
                    w_alu     = w_exec.alu;
                    w_signext = w_exec.sign_ext;
                    w_next    = S_WB;
                end
                S_WB: begin
                    w_regwrite = 1'b1;
                    w_regdst   = (r_opcode == OP_RTYPE);
                    w_next     = S_FETCH;
                end
                S_MEMADDR: begin
                    w_alusrca = 1'b1;
                    w_alusrcb = 2'b10;
                    w_signext = 1'b1;
                    w_alu     = ALU_ADD;
                    w_next    = S_MEMACC;
                end
                S_MEMACC: begin
                    w_iord     = 1'b1;
                    w_memread  = (r_opcode == OP_LW);
                    w_memwrite = (r_opcode == OP_SW);
                    if (bus.MemReady) begin
                        w_next = (r_opcode == OP_LW) ? S_MEMWB : S_FETCH;
                    end else if (w_expired) begin
                        w_next = S_TRAP;
                    end
                end
                S_MEMWB: begin
                    w_regwrite = 1'b1;
                    w_memtoreg = 1'b1;
                    w_next     = S_FETCH;
                end
                S_BRANCH: begin
                    w_alusrca  = 1'b1;
                    w_alu      = ALU_SUB;
                    w_pcsource = 2'b01;
                    w_pcwrite  = bus.Zero;
                    w_next     = S_FETCH;
                end
                S_JUMP: begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'b10;
                    w_next     = S_FETCH;
                end
                S_TRAP: begin
                    w_trap = 1'b1;
                end
                default: begin
                    w_next = S_TRAP;
                end
            endcase
        end
    end

    assign bus.PCWrite    = w_pcwrite;
    assign bus.IRWrite    = w_irwrite;
    assign bus.IorD       = w_iord;
    assign bus.MemRead    = w_memread;
    assign bus.MemWrite   = w_memwrite;
    assign bus.MemToReg   = w_memtoreg;
    assign bus.RegDst     = w_regdst;
    assign bus.RegWrite   = w_regwrite;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.SignExtend = w_signext;
    assign bus.Trap       = w_trap;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.PCSource   = w_pcsource;
    assign bus.ALUOp      = ALUOP_WIDTH'(w_alu);
endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter ALUOP_WIDTH, default 4: ALUOp width, must be >=4; codes zero-extended in the upper bits.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles spent waiting for MemReady before trapping, range 1..255.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Opcode, input, 6: instruction[31:26] from the external IR; valid from DECODE onward.
REQ-006 SHALL have port Zero, input, 1: ALU zero flag.
REQ-007 SHALL have port MemReady, input, 1: memory completion strobe for the current access.
REQ-008 SHALL have ports PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA, SignExtend, Trap, each output, 1.
REQ-009 SHALL have ports ALUSrcB and PCSource, output, 2 each.
REQ-010 SHALL have port ALUOp, output, ALUOP_WIDTH, using team ALU codes: AND 0, OR 1, ADD 2, SUB 6, SLT 7, ADDU 8, XOR A, SLTU B, LUI E, FUNC F.

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, WB, MEMADDR, MEMACC, MEMWB, BRANCH, JUMP, TRAP.
REQ-012 SHALL drive outputs from the registered state, the latched opcode and Zero/MemReady only; every output not listed for a state is 0.
REQ-013 FETCH: MemRead=1, ALUSrcB=01, ALUOp=ADD; on MemReady: IRWrite=1, PCWrite=1, PCSource=00, go to DECODE; otherwise stay in FETCH.
REQ-014 DECODE: latch Opcode; ALUSrcB=11, ALUOp=ADD, SignExtend=1 (branch target).
REQ-015 DECODE transitions: R-type/ORI/ADDI/ADDIU/ANDI/LUI/SLTI/SLTIU/XORI go to EXEC; LW/SW go to MEMADDR; BEQ goes to BRANCH; J goes to JUMP; any other opcode goes to TRAP.
REQ-016 EXEC: ALUSrcA=1; ALUSrcB=00 for R-type, 10 otherwise.
REQ-017 EXEC ALUOp/SignExtend by opcode: R FUNC/0, ORI OR/0, ADDI ADD/1, ADDIU ADDU/0, ANDI AND/0, LUI LUI/0, SLTI SLT/1, SLTIU SLTU/1, XORI XOR/0; next state WB.
REQ-018 WB: RegWrite=1; RegDst=1 for R-type, else 0; next state FETCH.
REQ-019 MEMADDR: ALUSrcA=1, ALUSrcB=10, SignExtend=1, ALUOp=ADD; next state MEMACC.
REQ-020 MEMACC: IorD=1; MemRead=1 for LW, MemWrite=1 for SW; on MemReady, LW goes to MEMWB and SW goes to FETCH.
REQ-021 MEMWB: RegWrite=1, MemToReg=1; next state FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWrite=Zero; next state FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEMACC, increment each cycle MemReady=0 there, and saturate (no wrap).
REQ-025 If the counter reaches MEM_TIMEOUT while MemReady=0, the next state SHALL be TRAP; MemReady seen in that same cycle takes priority over the timeout.
REQ-026 TRAP: Trap=1, all write enables 0; sticky until Reset.
REQ-027 Latency with MemReady=1 on first request: R/I 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Reset
REQ-028 Reset=1 at a rising CLK edge SHALL force FETCH, clear the counter and clear the latched opcode to 0, taking priority over all transitions, including mid-access and in TRAP.
REQ-029 While Reset is asserted, all 1-bit outputs except MemRead SHALL be 0, ALUOp SHALL be ADD, and ALUSrcB SHALL be 01.

Structure
REQ-030 Opcode defines, ALU-code defines and state encodings SHALL live in a shared package/include used by the control unit and the ALU control.
REQ-031 The wait counter SHALL be a sub-module, mem_wait_timer (clear, enable, limit, expired).

Verification
REQ-032 ADD R-type (Opcode 000000), MemReady=1 -> FETCH,DECODE,EXEC,WB; ALUOp=F in EXEC; RegWrite=1, RegDst=1 in WB only.
REQ-033 LW (100011) with MemReady delayed 3 cycles in MEMACC -> IorD=1, MemRead=1 held 4 cycles; MEMWB has MemToReg=1, RegWrite=1; 8 cycles total.
REQ-034 BEQ (000100) with Zero=1 and then Zero=0 -> PCWrite=1, PCSource=01 in BRANCH for the first; PCWrite=0 for the second.
REQ-035 Opcode 111111 -> TRAP after DECODE; Trap stays 1 for 20 cycles; Reset returns to FETCH.
REQ-036 MEM_TIMEOUT=4 with MemReady=0 in FETCH -> TRAP after 4 wait cycles; MemReady on the 4th cycle -> DECODE instead.
REQ-037 Reset asserted during MEMACC of SW -> MemWrite=0 and FETCH state after that edge.
